csi2tx_dphy_pwr_seq: RTL and testbench

- Power-up/power-down sequencer for the CSI-2 TX D-PHY model's clock/reset unit.
- Drives the D-PHY enable, the HS byte-domain reset and the per-lane escape-domain resets, with programmable dwell times.
- The PHY comes up in a fixed order: enable, then byte clock, then lanes one at a time in ascending index.
- Sits between the link controller (level request) and the D-PHY clock/reset unit; runs on the TX escape clock.

---
 rtl/csi2tx_dphy_pwr_seq_if.sv | 28 ++
 rtl/csi2tx_dphy_pwr_seq.sv | 167 ++++++++++++++++
 tb/tb_csi2tx_dphy_pwr_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/csi2tx_dphy_pwr_seq_if.sv
// Link-controller <-> power sequencer bundle.
// master: link controller (request, lane mask, dwell config)
// slave : sequencer (D-PHY enable, byte/lane resets, status)
interface csi2tx_dphy_pwr_seq_if #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned CNT_W     = 16
);
    logic                 phy_on_req;
    logic [NUM_LANES-1:0] lane_mask;
    logic [CNT_W-1:0]     t_init_cfg;
    logic [CNT_W-1:0]     t_off_cfg;
    logic                 dphy_enable;
    logic                 tx_byte_rst_n;
    logic [NUM_LANES-1:0] lane_rst_n;
    logic                 phy_ready;
    logic                 seq_busy;
    logic                 seq_err;

    modport master (
        output phy_on_req, lane_mask, t_init_cfg, t_off_cfg,
        input  dphy_enable, tx_byte_rst_n, lane_rst_n, phy_ready, seq_busy, seq_err
    );

    modport slave (
        input  phy_on_req, lane_mask, t_init_cfg, t_off_cfg,
        output dphy_enable, tx_byte_rst_n, lane_rst_n, phy_ready, seq_busy, seq_err
    );
endinterface

// File: rtl/csi2tx_dphy_pwr_seq.sv
// CSI-2 TX D-PHY power-up/power-down sequencer.
// Brings the PHY up as enable -> byte reset release -> lane resets released in
// ascending index, with programmable dwells; tears it down on request drop.
// Ports:
//   txclkesc        escape clock (rising edge)
//   txescclk_rst_n  async active-low reset
//   bus             slave side of csi2tx_dphy_pwr_seq_if (request/config in,
//                   enable/resets/status out, all registered)
module csi2tx_dphy_pwr_seq #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned T_BYTE    = 8,
    parameter int unsigned T_LANE    = 4
) (
    input  logic                     txclkesc,
    input  logic                     txescclk_rst_n,
    csi2tx_dphy_pwr_seq_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT_WAIT = 3'd1,
        BYTE_WAIT = 3'd2,
        LANE_REL  = 3'd3,
        READY     = 3'd4,
        SHUTDN    = 3'd5,
        OFF_WAIT  = 3'd6
    } state_t;

    // Counter reload values: a dwell of N occupies max(N,1) cycles.
    localparam logic [CNT_W-1:0] BYTE_LOAD = CNT_W'((T_BYTE > 0) ? T_BYTE - 1 : 0);
    localparam logic [CNT_W-1:0] LANE_LOAD = CNT_W'((T_LANE > 0) ? T_LANE - 1 : 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LANES-1:0] pend_q, pend_d;     // masked lanes still held in reset
    logic [NUM_LANES-1:0] lanes_q, lanes_d;
    logic                 en_q, en_d;
    logic                 byte_q, byte_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [NUM_LANES-1:0] first_c;

    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    // Isolate the lowest set bit of the pending-lane vector.
    assign first_c = pend_q & (~pend_q + NUM_LANES'(1));

    // State and output registers.
    always_ff @(posedge txclkesc or negedge txescclk_rst_n) begin
        if (!txescclk_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            lanes_q <= '0;
            en_q    <= 1'b0;
            byte_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            lanes_q <= lanes_d;
            en_q    <= en_d;
            byte_q  <= byte_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        lanes_d = lanes_q;
        en_d    = en_q;
        byte_d  = byte_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.phy_on_req) begin
                    if (bus.lane_mask != '0) begin
                        state_d = INIT_WAIT;
                        en_d    = 1'b1;
                        pend_d  = bus.lane_mask;
                        cnt_d   = dwell_load(bus.t_init_cfg);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            INIT_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = BYTE_WAIT;
                    cnt_d   = BYTE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BYTE_WAIT: begin
                // Byte reset and the first lane come out of reset together.
                if (cnt_q == '0) begin
                    state_d = LANE_REL;
                    byte_d  = 1'b1;
                    lanes_d = lanes_q | first_c;
                    pend_d  = pend_q & ~first_c;
                    cnt_d   = LANE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LANE_REL: begin
                if (pend_q == '0) begin
                    state_d = READY;
                end else if (cnt_q == '0) begin
                    lanes_d = lanes_q | first_c;
                    pend_d  = pend_q & ~first_c;
                    cnt_d   = LANE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READY: ;
            SHUTDN: begin
                state_d = OFF_WAIT;
            end
            OFF_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Request drop during bring-up or READY overrides normal progress.
        if (!bus.phy_on_req && (state_q == INIT_WAIT || state_q == BYTE_WAIT ||
                                state_q == LANE_REL  || state_q == READY)) begin
            state_d = SHUTDN;
            lanes_d = '0;
            byte_d  = 1'b0;
            pend_d  = '0;
            cnt_d   = dwell_load(bus.t_off_cfg);
        end

        ready_d = (state_d == READY);
        busy_d  = (state_d != IDLE) && (state_d != READY);
    end

    assign bus.dphy_enable   = en_q;
    assign bus.tx_byte_rst_n = byte_q;
    assign bus.lane_rst_n    = lanes_q;
    assign bus.phy_ready     = ready_q;
    assign bus.seq_busy      = busy_q;
    assign bus.seq_err       = err_q;

endmodule

// File: tb/tb_csi2tx_dphy_pwr_seq.sv
// Directed bench for csi2tx_dphy_pwr_seq: expected output snapshots are queued
// with their cycle offset when stimulus is applied and checked as cycles elapse.
module tb_csi2tx_dphy_pwr_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csi2tx_dphy_pwr_seq_if #(.NUM_LANES(8), .CNT_W(16)) bus ();

    csi2tx_dphy_pwr_seq #(
        .NUM_LANES(8), .CNT_W(16), .T_BYTE(8), .T_LANE(4)
    ) dut (
        .txclkesc       (clk),
        .txescclk_rst_n (rst_n),
        .bus            (bus)
    );

    // {dphy_enable, tx_byte_rst_n, lane_rst_n[7:0], phy_ready, seq_busy, seq_err}
    logic [12:0] obs;
    assign obs = {bus.dphy_enable, bus.tx_byte_rst_n, bus.lane_rst_n,
                  bus.phy_ready, bus.seq_busy, bus.seq_err};

    typedef struct {
        int          cyc;
        string       tag;
        logic [12:0] exp;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    t0 = 0;
    int    n_total = 0;
    int    n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] mk(input logic en, input logic byt,
                                       input logic [7:0] ln, input logic rdy,
                                       input logic busy, input logic err);
        return {en, byt, ln, rdy, busy, err};
    endfunction

    task automatic cmp(input string tag, input logic [12:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input int k, input string tag, input logic [12:0] exp);
        item_t it;
        it.cyc = t0 + k;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    // Step cycles, checking queued expectations as their cycle comes up.
    task automatic run_sb(input int budget);
        int    n;
        item_t it;
        n = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            n++;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                it = sb.pop_front();
                cmp(it.tag, it.exp);
            end
            if (sb.size() > 0 && n >= budget) begin
                n_total++;
                $error("FAIL timeout: %0d expectations pending, next %s", sb.size(), sb[0].tag);
                sb.delete();
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.phy_on_req = 1'b0;
        bus.lane_mask  = 8'h00;
        bus.t_init_cfg = 16'd0;
        bus.t_off_cfg  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_vals", mk(0, 0, 8'h00, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bring-up, lanes 0..3, T_INIT = 10
        bus.lane_mask  = 8'h0F;
        bus.t_init_cfg = 16'd10;
        bus.phy_on_req = 1'b1;
        t0 = cyc;
        push(1,  "up_enable",    mk(1, 0, 8'h00, 0, 1, 0));
        push(18, "up_pre_byte",  mk(1, 0, 8'h00, 0, 1, 0));
        push(19, "up_byte_l0",   mk(1, 1, 8'h01, 0, 1, 0));
        push(22, "up_l0_hold",   mk(1, 1, 8'h01, 0, 1, 0));
        push(23, "up_l1",        mk(1, 1, 8'h03, 0, 1, 0));
        push(27, "up_l2",        mk(1, 1, 8'h07, 0, 1, 0));
        push(31, "up_l3",        mk(1, 1, 8'h0F, 0, 1, 0));
        push(32, "up_ready",     mk(1, 1, 8'h0F, 1, 0, 0));
        run_sb(200);

        // lane_mask changes in READY are ignored
        bus.lane_mask = 8'hFF;
        t0 = cyc;
        push(4, "ready_mask_ignored", mk(1, 1, 8'h0F, 1, 0, 0));
        run_sb(50);

        // Shutdown from READY, T_OFF = 5
        bus.t_off_cfg  = 16'd5;
        bus.phy_on_req = 1'b0;
        t0 = cyc;
        push(1, "sd_entry",    mk(1, 0, 8'h00, 0, 1, 0));
        push(6, "sd_off_last", mk(1, 0, 8'h00, 0, 1, 0));
        push(7, "sd_idle",     mk(0, 0, 8'h00, 0, 0, 0));
        run_sb(50);

        // Sparse mask 1000_0101, T_INIT = 0
        bus.lane_mask  = 8'h85;
        bus.t_init_cfg = 16'd0;
        bus.phy_on_req = 1'b1;
        t0 = cyc;
        push(1,  "sp_enable",   mk(1, 0, 8'h00, 0, 1, 0));
        push(9,  "sp_pre_byte", mk(1, 0, 8'h00, 0, 1, 0));
        push(10, "sp_l0",       mk(1, 1, 8'h01, 0, 1, 0));
        push(13, "sp_l0_hold",  mk(1, 1, 8'h01, 0, 1, 0));
        push(14, "sp_l2",       mk(1, 1, 8'h05, 0, 1, 0));
        push(17, "sp_l2_hold",  mk(1, 1, 8'h05, 0, 1, 0));
        push(18, "sp_l7",       mk(1, 1, 8'h85, 0, 1, 0));
        push(19, "sp_ready",    mk(1, 1, 8'h85, 1, 0, 0));
        run_sb(100);

        // Shutdown with T_OFF = 0 (treated as 1)
        bus.t_off_cfg  = 16'd0;
        bus.phy_on_req = 1'b0;
        t0 = cyc;
        push(1, "sd0_entry", mk(1, 0, 8'h00, 0, 1, 0));
        push(2, "sd0_off",   mk(1, 0, 8'h00, 0, 1, 0));
        push(3, "sd0_idle",  mk(0, 0, 8'h00, 0, 0, 0));
        run_sb(50);

        // Abort after two of four lanes released
        bus.lane_mask  = 8'h0F;
        bus.t_init_cfg = 16'd2;
        bus.phy_on_req = 1'b1;
        t0 = cyc;
        push(11, "ab_l0", mk(1, 1, 8'h01, 0, 1, 0));
        push(15, "ab_l1", mk(1, 1, 8'h03, 0, 1, 0));
        run_sb(100);

        bus.t_off_cfg  = 16'd3;
        bus.phy_on_req = 1'b0;
        t0 = cyc;
        push(1, "ab_shutdn",  mk(1, 0, 8'h00, 0, 1, 0));
        push(2, "ab_offwait", mk(1, 0, 8'h00, 0, 1, 0));
        run_sb(50);

        // Re-request during OFF_WAIT: honoured only once back in IDLE
        bus.phy_on_req = 1'b1;
        push(4,  "ab_req_ignored", mk(1, 0, 8'h00, 0, 1, 0));
        push(5,  "ab_idle",        mk(0, 0, 8'h00, 0, 0, 0));
        push(6,  "ab_restart",     mk(1, 0, 8'h00, 0, 1, 0));
        push(16, "ab_re_l0",       mk(1, 1, 8'h01, 0, 1, 0));
        push(29, "ab_re_ready",    mk(1, 1, 8'h0F, 1, 0, 0));
        run_sb(100);

        // Zero mask: sticky error, no enable
        bus.t_off_cfg  = 16'd0;
        bus.phy_on_req = 1'b0;
        t0 = cyc;
        push(3, "zm_pre_idle", mk(0, 0, 8'h00, 0, 0, 0));
        run_sb(50);

        bus.lane_mask  = 8'h00;
        bus.phy_on_req = 1'b1;
        t0 = cyc;
        push(1, "zm_err",        mk(0, 0, 8'h00, 0, 0, 1));
        push(4, "zm_err_sticky", mk(0, 0, 8'h00, 0, 0, 1));
        run_sb(50);

        bus.lane_mask  = 8'h01;
        bus.t_init_cfg = 16'd0;
        t0 = cyc;
        push(1,  "zm_up",    mk(1, 0, 8'h00, 0, 1, 1));
        push(10, "zm_l0",    mk(1, 1, 8'h01, 0, 1, 1));
        push(11, "zm_ready", mk(1, 1, 8'h01, 1, 0, 1));
        run_sb(50);

        // Async reset during OFF_WAIT
        bus.t_off_cfg  = 16'd20;
        bus.phy_on_req = 1'b0;
        t0 = cyc;
        push(1, "ar_shutdn",  mk(1, 0, 8'h00, 0, 1, 1));
        push(3, "ar_offwait", mk(1, 0, 8'h00, 0, 1, 1));
        run_sb(50);

        #2;
        rst_n = 1'b0;
        #1;
        cmp("ar_immediate", mk(0, 0, 8'h00, 0, 0, 0));
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp("ar_idle_after", mk(0, 0, 8'h00, 0, 0, 0));

        bus.lane_mask  = 8'h01;
        bus.phy_on_req = 1'b1;
        t0 = cyc;
        push(1, "ar_fresh_start", mk(1, 0, 8'h00, 0, 1, 0));
        run_sb(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
